// File: rtl/ahb_sram_sif.sv
// ahb_sram_sif: AHB-Lite slave memory model with a write-only print/exit mailbox.
//
// Backing store of DEPTH words of DW bits starting at byte address BASE_ADDR, with
// byte-lane writes for every legal HSIZE, WAIT_STATES extra data-phase cycles per
// transfer, and a mailbox at MAILBOX_ADDR that reports the written byte for one cycle.
//
// Build option: define AHB_SRAM_SIF_ERR_EN to answer illegal transfers with the
// two-cycle ERROR response. Without it, illegal transfers complete OKAY with normal
// wait states, writes are dropped and reads return 0.
//
// Ports:
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,  AHB-Lite address phase (HBURST, HPROT ignored)
//   HWRITE, HSIZE, HREADY
//   HWDATA                write data, valid in the data phase
//   HREADYOUT, HRESP      data-phase handshake and response
//   HRDATA                read data, 0 outside a read data cycle
//   mailbox_wr            one-cycle pulse after a completed mailbox write
//   mailbox_data          byte written to the mailbox

module ahb_sram_sif #(
  parameter int unsigned DW           = 64,
  parameter int unsigned DEPTH        = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned WAIT_STATES  = 0,
  parameter logic [31:0] MAILBOX_ADDR = 32'hD058_0000
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [2:0]    HBURST,
  input  logic [3:0]    HPROT,
  input  logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [DW-1:0] HRDATA,
  output logic          mailbox_wr,
  output logic [7:0]    mailbox_data
);

`ifdef AHB_SRAM_SIF_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  localparam int unsigned NB   = DW / 8;
  localparam int unsigned Lsb  = $clog2(NB);
  localparam int unsigned IdxW = $clog2(DEPTH);
  // 64-bit bounds so that a memory ending at 4 GiB does not wrap.
  localparam logic [63:0] BaseExt = {32'h0, BASE_ADDR};
  localparam logic [63:0] TopExt  = BaseExt + 64'(DEPTH) * 64'(NB);

  typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

  logic [DW-1:0] mem [DEPTH];

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             hreadyout_q;
  logic             hresp_q;
  logic             write_q;
  logic             legal_q;
  logic             mbox_q;
  logic [IdxW-1:0]  idx_q;
  logic [Lsb-1:0]   lane_q;
  logic [NB-1:0]    bmask_q;
  logic             mailbox_wr_q;
  logic [7:0]       mailbox_data_q;

  // Address-phase decode
  logic          accept;
  logic [63:0]   haddr_ext;
  logic [31:0]   offset;
  logic [31:0]   align_mask;
  logic          in_range;
  logic          is_mbox;
  logic          size_ok;
  logic          aligned;
  logic          legal;
  logic [15:0]   size_bytes_mask;
  logic [15:0]   lane_mask;
  logic [NB-1:0] bmask;

  assign accept     = HSEL & HTRANS[1] & HREADY;
  assign haddr_ext  = {32'h0, HADDR};
  assign offset     = HADDR - BASE_ADDR;
  assign align_mask = ~(32'hFFFF_FFFF << HSIZE);
  assign in_range   = (haddr_ext >= BaseExt) && (haddr_ext < TopExt);
  assign is_mbox    = (HADDR == MAILBOX_ADDR);
  assign size_ok    = (HSIZE <= 3'(Lsb));
  assign aligned    = ((HADDR & align_mask) == 32'h0);
  // Mailbox is write-only; a mailbox read is illegal.
  assign legal      = size_ok && aligned && (in_range || (is_mbox && HWRITE));

  // 2^HSIZE ones shifted to the addressed lane; only meaningful when size_ok.
  always_comb begin
    size_bytes_mask = (16'd1 << (16'd1 << HSIZE)) - 16'd1;
    lane_mask       = size_bytes_mask << HADDR[Lsb-1:0];
    bmask           = lane_mask[NB-1:0];
  end

  logic mem_we;
  assign mem_we = (state_q == StData) && write_q && legal_q && !mbox_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q        <= StIdle;
      cnt_q          <= 4'd0;
      hreadyout_q    <= 1'b1;
      hresp_q        <= 1'b0;
      write_q        <= 1'b0;
      legal_q        <= 1'b0;
      mbox_q         <= 1'b0;
      idx_q          <= '0;
      lane_q         <= '0;
      bmask_q        <= '0;
      mailbox_wr_q   <= 1'b0;
      mailbox_data_q <= 8'h00;
    end else begin
      mailbox_wr_q <= 1'b0;
      if ((state_q == StData) && write_q && legal_q && mbox_q) begin
        mailbox_wr_q   <= 1'b1;
        mailbox_data_q <= HWDATA[{lane_q, 3'b000} +: 8];
      end

      unique case (state_q)
        StWait: begin
          if (cnt_q <= 4'd1) begin
            state_q     <= StData;
            cnt_q       <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StErr1: begin
          state_q     <= StErr2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        StIdle, StData, StErr2: begin
          if (accept) begin
            write_q <= HWRITE;
            legal_q <= legal;
            mbox_q  <= is_mbox;
            idx_q   <= offset[Lsb +: IdxW];
            lane_q  <= HADDR[Lsb-1:0];
            bmask_q <= bmask;
            if (!legal && ErrEn) begin
              state_q     <= StErr1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (WAIT_STATES != 0) begin
              state_q     <= StWait;
              cnt_q       <= 4'(WAIT_STATES);
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
            end else begin
              state_q     <= StData;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
            end
          end else begin
            state_q     <= StIdle;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
        end
      endcase
    end
  end

  // Memory is not reset; an asynchronous reset forces StIdle, discarding a pending write.
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (bmask_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  // Combinational read so a write committing at the edge that opens this read is visible.
  assign HRDATA = ((state_q == StData) && !write_q && legal_q && !mbox_q) ? mem[idx_q] : '0;

  assign HREADYOUT    = hreadyout_q;
  assign HRESP        = hresp_q;
  assign mailbox_wr   = mailbox_wr_q;
  assign mailbox_data = mailbox_data_q;

  logic unused_sigs;
  assign unused_sigs = ^{HBURST, HPROT, HTRANS[0], offset};

endmodule

// File: doc/ahb_sram_sif.md
# ahb_sram_sif

Parametrised AHB-Lite slave memory model for the core testbench, sitting on the LSU/IFU/DMA AHB ports as a backing store plus a print/exit mailbox. Generalises the fixed 64-bit zero-wait slave with configurable data width, depth, base address, programmable wait states, proper byte-lane writes for all legal sizes, and a spec-compliant two-cycle ERROR response. A state machine sequences address phase, wait states and error phases.

## Interface
- DW, 64: data bus width, 32 or 64.
- DEPTH, 4096: memory depth in DW-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- WAIT_STATES, 0: extra data-phase cycles (0-15) with HREADYOUT low per transfer.
- MAILBOX_ADDR, 32'hD058_0000: write-only mailbox byte address, outside the memory range.
- HCLK  in  1  clock; all state updates on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write.
- HSIZE  in  3  log2 bytes of the transfer.
- HBURST  in  3  ignored; each beat is handled independently.
- HPROT  in  4  ignored.
- HWDATA  in  DW  write data, valid in the data phase.
- HREADY  in  1  bus ready; an address phase is accepted only when high.
- HREADYOUT  out  1  data phase complete.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  DW  read data.
- mailbox_wr  out  1  one-cycle pulse on a completed mailbox write.
- mailbox_data  out  8  HWDATA byte lane selected by HADDR at the mailbox write.

## Operation
- Accept when HSEL & HTRANS[1] & HREADY; latch address, HWRITE, HSIZE and the byte mask (2^HSIZE bytes at lane HADDR mod DW/8).
- Legal transfer: in range [BASE_ADDR, BASE_ADDR+DEPTH*DW/8) or write to MAILBOX_ADDR; HSIZE <= log2(DW/8); HADDR aligned to 2^HSIZE.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on accept of a legal transfer go to WAIT (WAIT_STATES>0, counter loaded) or DATA; on accept of an illegal one go to ERR1 (error build only).
  - WAIT: HREADYOUT=0; decrement the counter and go to DATA when it reaches 1.
  - DATA: HREADYOUT=1, HRESP=0. The write commits the masked HWDATA into memory at the closing edge. A read drives HRDATA = mem[index], where index = (addr-BASE_ADDR) >> log2(DW/8). If a new accept occurs in the same cycle, branch as from IDLE; otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. Accepts are allowed; branch as from IDLE.
- IDLE/BUSY, or HSEL low: OKAY zero-wait response with no access.
- Mailbox write: memory untouched; mailbox_wr pulses on the cycle after the DATA cycle; mailbox_data is registered at the same edge.
- Mailbox read: treated as an illegal transfer.
- HRDATA is 0 outside a read DATA cycle.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, mailbox_wr=0, mailbox_data=0, FSM=IDLE, counter=0. Memory contents are not cleared.
- Reset asserted mid-transfer aborts immediately; a pending write is discarded.
- Latency: data phase = 1+WAIT_STATES cycles after the accept edge; an error takes exactly 2 cycles.
- Back-to-back write then read to the same address with WAIT_STATES=0 returns the new data, because the write commits at the edge that ends the read's address phase.
- Pipelined address phases are held by the master while HREADYOUT=0; they are sampled only at HREADY=1.
- Address wrap: HADDR below BASE_ADDR or at/above the top is out of range; there is no aliasing.

## Configuration
- AHB_SRAM_SIF_ERR_EN defined: illegal transfers take the ERR1/ERR2 path.
- AHB_SRAM_SIF_ERR_EN undefined: illegal transfers complete OKAY with normal wait states; writes are dropped and reads return 0.

## Test plan
- DW=64, WAIT_STATES=0: write HSIZE=2 0xDEADBEEF at 0x104, then read HSIZE=3 at 0x100 -> HRDATA[63:32]=0xDEADBEEF, HRDATA[31:0] unchanged, HREADYOUT never low.
- WAIT_STATES=3: single read -> HREADYOUT low for exactly 3 cycles, then HRDATA valid for 1 cycle, then 0.
- Error build: read at BASE_ADDR+DEPTH*8 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, then OKAY.
- Byte write 0x41 to MAILBOX_ADDR+0 -> mailbox_wr high 1 cycle with mailbox_data=0x41; the memory word at index 0 is unchanged.
- Misaligned HSIZE=1 at 0x101 -> ERROR with the macro defined; OKAY with memory unchanged when undefined.
- HRESETn low during WAIT of a write -> outputs return to reset values; a later read of that address returns the old data.
